// File: rtl/itu656_stream_decoder.sv
// BT.656 byte-stream decoder: locks to EAV/SAV codes, recovers F/V/H flags
// and demultiplexes Cb/Y/Cr/Y into per-pixel YCbCr with X/Y coordinates.
module itu656_stream_decoder #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             iCLK_27,
  input  logic             iRST,
  input  logic [7:0]       iTD_DATA,
  input  logic             iTD_Stable,
  output logic [7:0]       oY,
  output logic [7:0]       oCb,
  output logic [7:0]       oCr,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oTV_X,
  output logic [CNT_W-1:0] oTV_Y,
  output logic             oField,
  output logic             oVBlank,
  output logic             oHBlank,
  output logic             oTRS_Err
);

  localparam logic [2:0] SEEK   = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] ACTIVE = 3'd4;
  localparam logic [2:0] BLANK  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       cb_q, cb_d;
  logic [7:0]       y0_q, y0_d;
  logic [7:0]       cr_q, cr_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [7:0]       oy_q, oy_d;
  logic [7:0]       ocb_q, ocb_d;
  logic [7:0]       ocr_q, ocr_d;
  logic             dval_q, dval_d;
  logic [CNT_W-1:0] tvx_q, tvx_d;
  logic             fld_q, fld_d;
  logic             vb_q, vb_d;
  logic             hb_q, hb_d;
  logic             err_q, err_d;

  logic             emit_c;
  logic [7:0]       emit_y_c;
  logic [7:0]       emit_cr_c;

  logic f_bit, v_bit, h_bit, xy_ok;

  // XY field decode and protection-bit check
  assign f_bit = iTD_DATA[6];
  assign v_bit = iTD_DATA[5];
  assign h_bit = iTD_DATA[4];
  assign xy_ok = iTD_DATA[7] &&
                 (iTD_DATA[3:0] == {v_bit ^ h_bit, f_bit ^ h_bit,
                                    f_bit ^ v_bit, f_bit ^ v_bit ^ h_bit});

  // Next-state, pixel assembly and output computation
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cb_d      = cb_q;
    y0_d      = y0_q;
    cr_d      = cr_q;
    x_d       = x_q;
    line_d    = line_q;
    oy_d      = oy_q;
    ocb_d     = ocb_q;
    ocr_d     = ocr_q;
    dval_d    = 1'b0;
    tvx_d     = tvx_q;
    fld_d     = fld_q;
    vb_d      = vb_q;
    hb_d      = hb_q;
    err_d     = 1'b0;
    emit_c    = 1'b0;
    emit_y_c  = 8'h00;
    emit_cr_c = 8'h00;

    case (state_q)
      SEEK, BLANK: begin
        if (iTD_DATA == 8'hFF) state_d = T1;
      end
      T1: state_d = (iTD_DATA == 8'h00) ? T2 : SEEK;
      T2: state_d = (iTD_DATA == 8'h00) ? T3 : SEEK;
      T3: begin
        if (!xy_ok) begin
          err_d   = 1'b1;
          state_d = SEEK;
        end else begin
          fld_d = f_bit;
          vb_d  = v_bit;
          hb_d  = h_bit;
          if (h_bit || v_bit) begin
            state_d = BLANK;
          end else begin
            state_d = ACTIVE;
            phase_d = 2'd0;
            x_d     = '0;
            // New field (or first line after vertical blanking) restarts Y
            if (vb_q || (f_bit != fld_q)) line_d = '0;
            else if (line_q != {CNT_W{1'b1}}) line_d = line_q + CNT_W'(1);
          end
        end
      end
      ACTIVE: begin
        if (iTD_DATA == 8'hFF) begin
          state_d = T1;
        end else begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: cb_d = iTD_DATA;
            2'd1: y0_d = iTD_DATA;
            2'd2: begin
              cr_d      = iTD_DATA;
              emit_c    = 1'b1;
              emit_y_c  = y0_q;
              emit_cr_c = iTD_DATA;
            end
            default: begin
              emit_c    = 1'b1;
              emit_y_c  = iTD_DATA;
              emit_cr_c = cr_q;
            end
          endcase
        end
      end
      default: state_d = SEEK;
    endcase

    // Pixels past the active width are dropped and X holds
    if (emit_c && (x_q < CNT_W'(H_ACTIVE))) begin
      dval_d = 1'b1;
      oy_d   = emit_y_c;
      ocb_d  = cb_q;
      ocr_d  = emit_cr_c;
      tvx_d  = x_q;
      x_d    = x_q + CNT_W'(1);
    end

    // Loss of stability drops lock; flags hold, counters restart
    if (!iTD_Stable) begin
      state_d = SEEK;
      dval_d  = 1'b0;
      fld_d   = fld_q;
      vb_d    = vb_q;
      hb_d    = hb_q;
      x_d     = '0;
      line_d  = '0;
      phase_d = 2'd0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iCLK_27) begin
    if (iRST) begin
      state_q <= SEEK;
      phase_q <= 2'd0;
      cb_q    <= 8'h00;
      y0_q    <= 8'h00;
      cr_q    <= 8'h00;
      x_q     <= '0;
      line_q  <= '0;
      oy_q    <= 8'h00;
      ocb_q   <= 8'h00;
      ocr_q   <= 8'h00;
      dval_q  <= 1'b0;
      tvx_q   <= '0;
      fld_q   <= 1'b0;
      vb_q    <= 1'b0;
      hb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cb_q    <= cb_d;
      y0_q    <= y0_d;
      cr_q    <= cr_d;
      x_q     <= x_d;
      line_q  <= line_d;
      oy_q    <= oy_d;
      ocb_q   <= ocb_d;
      ocr_q   <= ocr_d;
      dval_q  <= dval_d;
      tvx_q   <= tvx_d;
      fld_q   <= fld_d;
      vb_q    <= vb_d;
      hb_q    <= hb_d;
      err_q   <= err_d;
    end
  end

  assign oY       = oy_q;
  assign oCb      = ocb_q;
  assign oCr      = ocr_q;
  assign oDVAL    = dval_q;
  assign oTV_X    = tvx_q;
  assign oTV_Y    = line_q;
  assign oField   = fld_q;
  assign oVBlank  = vb_q;
  assign oHBlank  = hb_q;
  assign oTRS_Err = err_q;

endmodule

// File: tb/tb_itu656_stream_decoder.sv
// Testbench for itu656_stream_decoder: directed table, hand-written corner
// sequences and a randomized stream against a behavioural reference model.
module tb_itu656_stream_decoder;

  logic       clk;
  logic       rs;
  logic [7:0] din;
  logic       st;
  logic [7:0] oY, oCb, oCr;
  logic       oDVAL;
  logic [9:0] oTV_X, oTV_Y;
  logic       oField, oVBlank, oHBlank, oTRS_Err;

  itu656_stream_decoder #(.H_ACTIVE(720), .CNT_W(10)) dut (
    .iCLK_27(clk), .iRST(rs), .iTD_DATA(din), .iTD_Stable(st),
    .oY(oY), .oCb(oCb), .oCr(oCr), .oDVAL(oDVAL),
    .oTV_X(oTV_X), .oTV_Y(oTV_Y),
    .oField(oField), .oVBlank(oVBlank), .oHBlank(oHBlank),
    .oTRS_Err(oTRS_Err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: counts preamble bytes and payload bytes since SAV
  int         m_hdr, m_mode, m_cnt, m_x, m_y;
  logic [7:0] m_grp [4];
  logic       e_dval, e_err, e_f, e_v, e_h;
  logic [7:0] e_y, e_cb, e_cr;
  int         e_x;

  // Observed strobe bookkeeping for hand sequences
  int n_strobe, first_x, last_x;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_pixel(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    if (m_x < 720) begin
      e_dval = 1'b1;
      e_y = y; e_cb = cb; e_cr = cr; e_x = m_x;
      m_x++;
    end
  endtask

  task automatic model_step(input logic [7:0] b, input logic s, input logic r);
    logic f, v, h, ok;
    if (r) begin
      m_hdr = 0; m_mode = 0; m_cnt = 0; m_x = 0; m_y = 0;
      e_dval = 0; e_err = 0; e_f = 0; e_v = 0; e_h = 0;
      return;
    end
    e_dval = 1'b0;
    e_err  = 1'b0;
    if (m_hdr == 3) begin
      f = b[6]; v = b[5]; h = b[4];
      ok = b[7] && (b[3] == (v ^ h)) && (b[2] == (f ^ h)) &&
           (b[1] == (f ^ v)) && (b[0] == (f ^ v ^ h));
      m_hdr = 0;
      if (!ok) begin
        e_err = 1'b1; m_mode = 0;
      end else if (s) begin
        if (!h && !v) begin
          m_mode = 1; m_cnt = 0; m_x = 0;
          if (e_v || (f != e_f)) m_y = 0;
          else if (m_y < 1023) m_y++;
        end else begin
          m_mode = 2;
        end
        e_f = f; e_v = v; e_h = h;
      end
    end else if (m_hdr != 0) begin
      if (b == 8'h00) m_hdr++;
      else begin m_hdr = 0; m_mode = 0; end
    end else if (b == 8'hFF) begin
      m_hdr = 1; m_mode = 0;
    end else if (m_mode == 1) begin
      m_grp[m_cnt % 4] = b;
      if (m_cnt % 4 == 2) model_pixel(m_grp[1], m_grp[0], b);
      if (m_cnt % 4 == 3) model_pixel(b, m_grp[0], m_grp[2]);
      m_cnt++;
    end
    if (!s) begin
      m_hdr = 0; m_mode = 0; m_cnt = 0; m_x = 0; m_y = 0; e_dval = 1'b0;
    end
  endtask

  task automatic model_check();
    chk("dval", int'(oDVAL), int'(e_dval));
    chk("trs_err", int'(oTRS_Err), int'(e_err));
    chk("field", int'(oField), int'(e_f));
    chk("vblank", int'(oVBlank), int'(e_v));
    chk("hblank", int'(oHBlank), int'(e_h));
    chk("tv_y", int'(oTV_Y), m_y);
    if (e_dval) begin
      chk("pix_y", int'(oY), int'(e_y));
      chk("pix_cb", int'(oCb), int'(e_cb));
      chk("pix_cr", int'(oCr), int'(e_cr));
      chk("pix_x", int'(oTV_X), e_x);
    end
    if (oDVAL) begin
      if (n_strobe == 0) first_x = int'(oTV_X);
      last_x = int'(oTV_X);
      n_strobe++;
    end
  endtask

  task automatic step(input logic [7:0] b, input logic s, input logic r);
    din = b; st = s; rs = r;
    @(posedge clk);
    model_step(b, s, r);
    #1;
    model_check();
  endtask

  task automatic sav(input logic [7:0] xy);
    step(8'hFF, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(xy, 1'b1, 1'b0);
  endtask

  task automatic payload(input int n);
    for (int i = 0; i < n; i++) step(8'($urandom_range(0, 254)), 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic [7:0] y, cb, cr;
    int         x;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] codes [9];

  initial begin
    clk = 1'b0; rs = 1'b1; din = 8'h00; st = 1'b1;
    n_strobe = 0; first_x = -1; last_x = -1;
    codes = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1, 8'h81};
    tbl[0]  = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[1]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[2]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[3]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[4]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[5]  = '{8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[6]  = '{8'hA0, 1'b1, 8'h10, 8'h80, 8'hA0, 0};
    tbl[7]  = '{8'h20, 1'b1, 8'h20, 8'h80, 8'hA0, 1};
    tbl[8]  = '{8'hC0, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[9]  = '{8'h30, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    tbl[10] = '{8'hE0, 1'b1, 8'h30, 8'hC0, 8'hE0, 2};
    tbl[11] = '{8'h40, 1'b1, 8'h40, 8'hC0, 8'hE0, 3};

    // Reset state
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    chk("rst_y", int'(oY), 0);
    chk("rst_cb", int'(oCb), 0);
    chk("rst_cr", int'(oCr), 0);
    chk("rst_x", int'(oTV_X), 0);

    // Directed first line
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].d, 1'b1, 1'b0);
      chk("tbl_dval", int'(oDVAL), int'(tbl[i].dv));
      if (tbl[i].dv) begin
        chk("tbl_y", int'(oY), int'(tbl[i].y));
        chk("tbl_cb", int'(oCb), int'(tbl[i].cb));
        chk("tbl_cr", int'(oCr), int'(tbl[i].cr));
        chk("tbl_x", int'(oTV_X), tbl[i].x);
      end
    end

    // Full line with overrun bytes, then EAV
    sav(8'h80);
    n_strobe = 0;
    payload(1448);
    sav(8'h9D);
    chk("line_strobes", n_strobe, 720);
    chk("line_first_x", first_x, 0);
    chk("line_last_x", last_x, 719);
    chk("eav_flags", int'({oField, oVBlank, oHBlank}), 1);

    // Bad protection bits
    sav(8'h81);
    chk("bad_err", int'(oTRS_Err), 1);
    chk("bad_flags", int'({oField, oVBlank, oHBlank}), 1);
    n_strobe = 0;
    payload(8);
    chk("bad_err_clear", int'(oTRS_Err), 0);
    chk("bad_no_strobe", n_strobe, 0);

    // Partial group cut by a stray 0xFF
    sav(8'h80);
    n_strobe = 0;
    step(8'h80, 1'b1, 1'b0);
    step(8'h10, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    payload(4);
    chk("partial_no_strobe", n_strobe, 0);
    sav(8'h80);
    n_strobe = 0;
    payload(4);
    chk("resume_strobes", n_strobe, 2);
    chk("resume_first_x", first_x, 0);

    // Y counter across blanking and field change
    sav(8'hAB);
    chk("vb_set", int'(oVBlank), 1);
    sav(8'h80);
    chk("y_after_vb", int'(oTV_Y), 0);
    sav(8'h80);
    chk("y_incr", int'(oTV_Y), 1);
    sav(8'hC7);
    chk("y_field_change", int'(oTV_Y), 0);
    chk("field_one", int'(oField), 1);

    // Stability drop mid-line
    payload(4);
    step(8'h22, 1'b0, 1'b0);
    n_strobe = 0;
    payload(12);
    chk("unstable_no_strobe", n_strobe, 0);
    sav(8'hC7);
    n_strobe = 0;
    payload(4);
    chk("relock_strobes", n_strobe, 2);
    chk("relock_first_x", first_x, 0);

    // Reset mid-line on the byte that would strobe
    sav(8'hC7);
    step(8'h80, 1'b1, 1'b0);
    step(8'h10, 1'b1, 1'b0);
    step(8'hA0, 1'b1, 1'b1);
    chk("mrst_dval", int'(oDVAL), 0);
    chk("mrst_all", int'({oY, oCb, oCr, oTV_X, oTV_Y, oField, oVBlank, oHBlank, oTRS_Err}), 0);
    step(8'h00, 1'b1, 1'b0);

    // Randomized stream against the model
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      sav(codes[$urandom_range(0, 8)]);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1400, 1500) : $urandom_range(0, 60);
      for (int i = 0; i < len; i++)
        step(8'($urandom_range(0, 255)), ($urandom_range(0, 79) != 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
